// File: rtl/ethernet_tx_pkg.sv
// Shared constants and state encoding for the Ethernet frame transmitter.
package ethernet_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        PAD,
        FCS,
        IPG
    } state_e;

    localparam logic [7:0]  PREAMBLE_BYTE     = 8'h55;
    localparam logic [7:0]  SFD_BYTE          = 8'hD5;
    localparam int          MIN_PAYLOAD_BYTES = 46;
    localparam int          IPG_BITS          = 96;
    localparam logic [31:0] CRC_POLY          = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT          = 32'hFFFFFFFF;

endpackage

// File: rtl/ethernet_tx_crc32_nbit.sv
// Reflected CRC-32 register advanced N bits per enabled cycle, bit 0 of the beat first.
module crc32_nbit
    import ethernet_tx_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [N-1:0] data_i,
    output logic [31:0]  crc_o
);

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            for (int i = 0; i < N; i++) begin
                crc_d = (crc_d[0] ^ data_i[i]) ? ((crc_d >> 1) ^ CRC_POLY) : (crc_d >> 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/ethernet_tx.sv
// Ethernet frame transmitter: wraps a streamed payload with preamble, MAC header,
// zero padding and FCS, emitting N bits per cycle, then holds off for the inter-packet gap.
module ethernet_tx
    import ethernet_tx_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] axiid,
    input  logic         axiiv,
    input  logic [47:0]  my_mac,
    input  logic [47:0]  dest_mac,
    input  logic [15:0]  etype,
    output logic         axiov,
    output logic [N-1:0] axiod
);

    localparam int         BPB       = 8 / N;
    localparam int         DLY       = 176 / N;
    localparam logic [7:0] PRE_LAST  = 8'(64 / N - 1);
    localparam logic [7:0] SFD_FIRST = 8'(7 * BPB);
    localparam logic [7:0] HDR_LAST  = 8'(112 / N - 1);
    localparam logic [7:0] FCS_LAST  = 8'(32 / N - 1);
    localparam logic [7:0] IPG_LAST  = 8'(IPG_BITS / N - 1);
    localparam logic [2:0] POS_LAST  = 3'(BPB - 1);
    localparam logic [5:0] MIN_BYTES = 6'(MIN_PAYLOAD_BYTES);

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [2:0]     pos_q, pos_d, pos_nx;
    logic [5:0]     bytes_q, bytes_d, bytes_nx;
    logic [111:0]   hdr_q, hdr_d, hdr_sh;
    logic           axiov_q, axiov_d;
    logic [N-1:0]   axiod_q, axiod_d;
    logic           acc_q, in_v;
    logic [N:0]     dl_q [DLY];
    logic           crc_clr, crc_en;
    logic [31:0]    crc, fcs_sh;
    int             cidx;

    function automatic logic [N-1:0] chunk(input logic [7:0] b, input int idx);
        logic [7:0] s;
        s = b >> (idx * N);
        return s[N-1:0];
    endfunction

    crc32_nbit #(.N(N)) u_crc (
        .clk_i (clk),
        .rst_ni(rst),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .data_i(axiod_d),
        .crc_o (crc)
    );

    // Beats are accepted only in the starting cycle and the unbroken run that follows it.
    assign in_v = axiiv && (acc_q || state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 8'd1;
        pos_d    = pos_q;
        bytes_d  = bytes_q;
        hdr_d    = hdr_q;
        axiov_d  = 1'b0;
        axiod_d  = '0;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        cidx     = int'(cnt_q);
        hdr_sh   = hdr_q >> (104 - 8 * (cidx / BPB) + N * (cidx % BPB));
        fcs_sh   = ~crc >> (cidx * N);
        pos_nx   = (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
        bytes_nx = (pos_q == POS_LAST && bytes_q < MIN_BYTES) ? bytes_q + 6'd1 : bytes_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (axiiv) begin
                    hdr_d   = {dest_mac, my_mac, etype};
                    crc_clr = 1'b1;
                    pos_d   = '0;
                    bytes_d = '0;
                    axiov_d = 1'b1;
                    axiod_d = chunk(PREAMBLE_BYTE, 0);
                    cnt_d   = 8'd1;
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                axiov_d = 1'b1;
                axiod_d = chunk((cnt_q < SFD_FIRST) ? PREAMBLE_BYTE : SFD_BYTE, cidx % BPB);
                if (cnt_q == PRE_LAST) begin
                    state_d = HEADER;
                    cnt_d   = '0;
                end
            end
            HEADER: begin
                axiov_d = 1'b1;
                axiod_d = hdr_sh[N-1:0];
                crc_en  = 1'b1;
                if (cnt_q == HDR_LAST) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                end
            end
            PAYLOAD: begin
                // The stage behind the tail tells us whether this is the final payload beat.
                axiov_d = 1'b1;
                axiod_d = dl_q[DLY-1][N] ? dl_q[DLY-1][N-1:0] : '0;
                crc_en  = 1'b1;
                pos_d   = pos_nx;
                bytes_d = bytes_nx;
                cnt_d   = '0;
                if (!dl_q[DLY-2][N]) begin
                    state_d = (pos_nx != 3'd0 || bytes_nx < MIN_BYTES) ? PAD : FCS;
                end
            end
            PAD: begin
                axiov_d = 1'b1;
                crc_en  = 1'b1;
                pos_d   = pos_nx;
                bytes_d = bytes_nx;
                cnt_d   = '0;
                if (pos_nx == 3'd0 && bytes_nx >= MIN_BYTES) begin
                    state_d = FCS;
                end
            end
            FCS: begin
                axiov_d = 1'b1;
                axiod_d = fcs_sh[N-1:0];
                if (cnt_q == FCS_LAST) begin
                    state_d = IPG;
                    cnt_d   = '0;
                end
            end
            IPG: begin
                if (cnt_q == IPG_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            bytes_q <= '0;
            hdr_q   <= '0;
            axiov_q <= 1'b0;
            axiod_q <= '0;
            acc_q   <= 1'b0;
            for (int i = 0; i < DLY; i++) dl_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            bytes_q <= bytes_d;
            hdr_q   <= hdr_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
            acc_q   <= in_v;
            dl_q[0] <= {in_v, axiid & {N{in_v}}};
            for (int i = 1; i < DLY; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;

endmodule

// File: tb/tb_ethernet_tx.sv
// Self-checking bench for ethernet_tx (N=2) against a byte-level frame model.
module tb_ethernet_tx;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] axiid;
    logic         axiiv;
    logic [47:0]  my_mac, dest_mac;
    logic [15:0]  etype;
    logic         axiov;
    logic [N-1:0] axiod;

    int checks = 0;
    int errors = 0;

    ethernet_tx #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .axiid   (axiid),
        .axiiv   (axiiv),
        .my_mac  (my_mac),
        .dest_mac(dest_mac),
        .etype   (etype),
        .axiov   (axiov),
        .axiod   (axiod)
    );

    always #5 clk = ~clk;

    // Monitor: capture valid beats, count frame starts/ends, measure idle gaps.
    logic [N-1:0] cap[$];
    int starts = 0, ends = 0, zero_run = 0, last_gap = 0;
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        if (axiov === 1'b1) begin
            cap.push_back(axiod);
            if (!prev_v) begin
                starts++;
                last_gap = zero_run;
            end
            zero_run = 0;
            prev_v = 1'b1;
        end else begin
            checks++;
            if (axiod !== '0) begin
                errors++;
                $display("FAIL idle_zero: axiod=%0h while axiov=0, required 0", axiod);
            end
            if (prev_v) ends++;
            zero_run++;
            prev_v = 1'b0;
        end
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Reference: assemble the frame as bytes, then serialize each byte LSB chunk first.
    task automatic build_frame(input logic [N-1:0] pay[$], input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] et, output logic [N-1:0] exp[$], output logic [31:0] fcs);
        logic [7:0]  fb[$];
        logic [7:0]  body[$];
        logic [47:0] t48;
        logic [15:0] t16;
        logic [7:0]  b, t8;
        logic [31:0] c;
        int          nb;
        fb = {};
        body = {};
        exp = {};
        for (int i = 0; i < 7; i++) fb.push_back(8'h55);
        fb.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) begin t48 = d >> (8 * i); body.push_back(t48[7:0]); end
        for (int i = 5; i >= 0; i--) begin t48 = s >> (8 * i); body.push_back(t48[7:0]); end
        t16 = et >> 8;
        body.push_back(t16[7:0]);
        body.push_back(et[7:0]);
        nb = (pay.size() * N + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int j = 0; j < 8 / N; j++) begin
                if (k * (8 / N) + j < pay.size()) b = b | (8'(pay[k * (8 / N) + j]) << (j * N));
            end
            body.push_back(b);
        end
        while (body.size() < 14 + 46) body.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (body[i]) c = crc_byte(c, body[i]);
        fcs = ~c;
        foreach (body[i]) fb.push_back(body[i]);
        for (int i = 0; i < 4; i++) begin t8 = 8'(fcs >> (8 * i)); fb.push_back(t8); end
        foreach (fb[k]) begin
            for (int j = 0; j < 8 / N; j++) begin
                t8 = fb[k] >> (j * N);
                exp.push_back(t8[N-1:0]);
            end
        end
    endtask

    task automatic scramble_inputs();
        dest_mac = 48'({$urandom(), $urandom()});
        my_mac   = 48'({$urandom(), $urandom()});
        etype    = 16'($urandom());
    endtask

    task automatic send_payload(input logic [N-1:0] pay[$]);
        foreach (pay[i]) begin
            @(negedge clk);
            axiiv = 1'b1;
            axiid = pay[i];
            if (i == 1) scramble_inputs();
        end
        @(negedge clk);
        axiiv = 1'b0;
        axiid = '0;
        scramble_inputs();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input string name, input logic [N-1:0] exp[$]);
        int e0;
        int bad;
        e0 = ends;
        for (int t = 0; t < 5000 && ends == e0; t++) @(negedge clk);
        checks++;
        if (ends == e0) begin
            errors++;
            $display("FAIL %s_timeout: frame end not seen, %0d beats captured", name, cap.size());
            return;
        end
        check({name, "_len"}, 64'(cap.size()), 64'(exp.size()));
        bad = -1;
        for (int i = 0; i < cap.size() && i < exp.size(); i++) begin
            if (bad < 0 && cap[i] !== exp[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_data: beat %0d got %0h, required %0h", name, bad, cap[bad], exp[bad]);
        end
    endtask

    function automatic logic [7:0] wire_byte(input int k);
        logic [7:0] b;
        b = '0;
        for (int j = 0; j < 8 / N; j++) b = b | (8'(cap[k * (8 / N) + j]) << (j * N));
        return b;
    endfunction

    typedef struct {
        int nbeats;
        int fixed;
        int exp_bytes;
    } vec_t;

    vec_t         vecs[7];
    logic [N-1:0] pay[$];
    logic [N-1:0] exp[$];
    logic [31:0]  fcs;
    logic [7:0]   hdr_lit[14];
    logic [31:0]  got_fcs;
    int           s0, nb;

    initial begin
        rst = 1'b0;
        axiiv = 1'b0;
        axiid = '0;
        scramble_inputs();
        vecs[0] = '{1, 2, 72};
        vecs[1] = '{240, -1, 86};
        vecs[2] = '{3, -1, 72};
        vecs[3] = '{184, -1, 72};
        vecs[4] = '{185, -1, 73};
        vecs[5] = '{201, -1, 77};
        vecs[6] = '{400, -1, 126};
        hdr_lit = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54,
                    8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'hAB, 8'h67, 8'h89};

        repeat (3) @(negedge clk);
        check("reset_axiov", 64'(axiov), 64'd0);
        check("reset_axiod", 64'(axiod), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[v]) begin
            pay = {};
            for (int i = 0; i < vecs[v].nbeats; i++)
                pay.push_back(vecs[v].fixed >= 0 ? N'(vecs[v].fixed) : N'($urandom_range(0, 3)));
            if (v == 0) begin
                dest_mac = 48'hFEDC_BA98_7654;
                my_mac   = 48'h1234_5678_90AB;
                etype    = 16'h6789;
            end else begin
                scramble_inputs();
            end
            build_frame(pay, dest_mac, my_mac, etype, exp, fcs);
            cap = {};
            send_payload(pay);
            expect_frame($sformatf("vec%0d", v), exp);
            check($sformatf("vec%0d_beats", v), 64'(cap.size()), 64'(vecs[v].exp_bytes * (8 / N)));
            if (v == 0 && cap.size() >= 288) begin
                for (int i = 0; i < 31; i++) check($sformatf("pre_beat%0d", i + 1), 64'(cap[i]), 64'd1);
                check("sfd_beat32", 64'(cap[31]), 64'd3);
                for (int k = 0; k < 14; k++) check($sformatf("hdr_byte%0d", k + 9), 64'(wire_byte(8 + k)), 64'(hdr_lit[k]));
                check("payload_byte23", 64'(wire_byte(22)), 64'h02);
            end
            if (v == 1 && cap.size() >= 344) begin
                got_fcs = {wire_byte(85), wire_byte(84), wire_byte(83), wire_byte(82)};
                check("fcs60", 64'(got_fcs), 64'(fcs));
            end
            repeat (50) @(negedge clk);
        end

        // Random-length frames against the model.
        for (int r = 0; r < 4; r++) begin
            pay = {};
            nb = $urandom_range(1, 300);
            for (int i = 0; i < nb; i++) pay.push_back(N'($urandom_range(0, 3)));
            scramble_inputs();
            build_frame(pay, dest_mac, my_mac, etype, exp, fcs);
            cap = {};
            send_payload(pay);
            expect_frame($sformatf("rand%0d", r), exp);
            repeat (50) @(negedge clk);
        end

        // Pulses during FCS and IPG are dropped; a start held through IPG begins after 48 idle cycles.
        s0 = starts;
        pay = '{2'b01};
        scramble_inputs();
        build_frame(pay, dest_mac, my_mac, etype, exp, fcs);
        cap = {};
        send_payload(pay);
        for (int t = 0; t < 1000 && cap.size() < 280; t++) @(negedge clk);
        @(negedge clk);
        axiiv = 1'b1;
        axiid = 2'b11;
        @(negedge clk);
        axiiv = 1'b0;
        axiid = '0;
        expect_frame("drop_fcs", exp);
        cap = {};
        repeat (5) @(negedge clk);
        axiiv = 1'b1;
        axiid = 2'b10;
        @(negedge clk);
        axiiv = 1'b0;
        repeat (5) @(negedge clk);
        pay = '{2'b11};
        scramble_inputs();
        build_frame(pay, dest_mac, my_mac, etype, exp, fcs);
        axiiv = 1'b1;
        axiid = 2'b11;
        for (int t = 0; t < 200 && axiov !== 1'b1; t++) @(negedge clk);
        axiiv = 1'b0;
        axiid = '0;
        scramble_inputs();
        check("restart_seen", 64'(axiov), 64'd1);
        expect_frame("after_ipg", exp);
        check("ipg_gap", 64'(last_gap >= 48), 64'd1);
        check("frame_count", 64'(starts - s0), 64'd2);
        repeat (50) @(negedge clk);

        // Asynchronous reset in the middle of the header, then a fresh start right after release.
        pay = '{2'b10};
        scramble_inputs();
        cap = {};
        send_payload(pay);
        for (int t = 0; t < 200 && cap.size() < 40; t++) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_rst_axiov", 64'(axiov), 64'd0);
        check("async_rst_axiod", 64'(axiod), 64'd0);
        repeat (3) @(negedge clk);
        check("held_rst_axiov", 64'(axiov), 64'd0);
        pay = '{2'b01};
        dest_mac = 48'hFEDC_BA98_7654;
        my_mac   = 48'h1234_5678_90AB;
        etype    = 16'h6789;
        build_frame(pay, dest_mac, my_mac, etype, exp, fcs);
        cap = {};
        rst = 1'b1;
        axiiv = 1'b1;
        axiid = 2'b01;
        @(posedge clk);
        #1;
        check("start_after_rst", 64'(axiov), 64'd1);
        @(negedge clk);
        axiiv = 1'b0;
        axiid = '0;
        scramble_inputs();
        expect_frame("post_rst", exp);
        repeat (50) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
